// File: rtl/uart_cmd_rcv.sv
// UART command endpoint: assembles 3-byte command frames (cmd, data hi,
// data lo) from the serial link into a parallel command word, and sends
// single-byte responses back over the same link. The 8-bit UART
// transceiver used underneath is included in this file so the block can
// be built on its own.

module UART #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    input  logic [7:0] tx_data,
    input  logic       trmt,
    output logic       tx_done,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    input  logic       clr_rx_rdy
);
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2 - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

    logic          tx_busy_q;
    logic [BW-1:0] tx_baud_q;
    logic [3:0]    tx_bit_q;
    logic [9:0]    tx_shift_q;
    logic          tx_done_q;

    logic          rx_meta_q;
    logic          rx_sync_q;
    logic          rx_busy_q;
    logic [BW-1:0] rx_baud_q;
    logic [3:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;
    logic [7:0]    rx_data_q;
    logic          rx_rdy_q;

    // Serialise start bit, 8 data bits LSB first and stop bit; the shift
    // register refills with ones so TX rests high between frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy_q  <= 1'b0;
            tx_baud_q  <= '0;
            tx_bit_q   <= 4'd0;
            tx_shift_q <= '1;
            tx_done_q  <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            if (!tx_busy_q) begin
                if (trmt) begin
                    tx_busy_q  <= 1'b1;
                    tx_baud_q  <= BAUD_LAST;
                    tx_bit_q   <= 4'd0;
                    tx_shift_q <= {1'b1, tx_data, 1'b0};
                end
            end else if (tx_baud_q == '0) begin
                tx_baud_q  <= BAUD_LAST;
                tx_shift_q <= {1'b1, tx_shift_q[9:1]};
                if (tx_bit_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                    tx_done_q <= 1'b1;
                end else begin
                    tx_bit_q <= tx_bit_q + 4'd1;
                end
            end else begin
                tx_baud_q <= tx_baud_q - BAUD_ONE;
            end
        end
    end

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Detect the start edge, sample each bit at its centre, and flag a
    // byte only when the stop bit is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_busy_q  <= 1'b0;
            rx_baud_q  <= '0;
            rx_bit_q   <= 4'd0;
            rx_shift_q <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_rdy_q   <= 1'b0;
        end else begin
            if (clr_rx_rdy) begin
                rx_rdy_q <= 1'b0;
            end
            if (!rx_busy_q) begin
                if (!rx_sync_q) begin
                    rx_busy_q <= 1'b1;
                    rx_baud_q <= BAUD_HALF;
                    rx_bit_q  <= 4'd0;
                end
            end else if (rx_baud_q == '0) begin
                rx_baud_q <= BAUD_LAST;
                if (rx_bit_q == 4'd0) begin
                    if (rx_sync_q) begin
                        rx_busy_q <= 1'b0;
                    end else begin
                        rx_bit_q <= 4'd1;
                    end
                end else if (rx_bit_q == 4'd9) begin
                    rx_busy_q <= 1'b0;
                    if (rx_sync_q) begin
                        rx_data_q <= rx_shift_q;
                        rx_rdy_q  <= 1'b1;
                    end
                end else begin
                    rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_q   <= rx_bit_q + 4'd1;
                end
            end else begin
                rx_baud_q <= rx_baud_q - BAUD_ONE;
            end
        end
    end

    assign TX      = tx_shift_q[0];
    assign tx_done = tx_done_q;
    assign rx_data = rx_data_q;
    assign rx_rdy  = rx_rdy_q;

endmodule

module uart_cmd_rcv #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int BAUD_DIV       = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent,
    output logic        tx_busy,
    output logic        frm_err,
    output logic        overrun
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {WAIT_CMD, WAIT_HI, WAIT_LO} rx_state_t;
    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

    rx_state_t        rx_state_q, rx_state_d;
    logic [7:0]       cmd_sh_q,   cmd_sh_d;
    logic [7:0]       hi_sh_q,    hi_sh_d;
    logic [7:0]       cmd_q,      cmd_d;
    logic [15:0]      data_q,     data_d;
    logic             cmd_rdy_q,  cmd_rdy_d;
    logic             overrun_q,  overrun_d;
    logic             frm_err_q,  frm_err_d;
    logic [CNT_W-1:0] to_cnt_q,   to_cnt_d;

    tx_state_t        tx_state_q, tx_state_d;
    logic [7:0]       resp_q,     resp_d;
    logic             resp_sent_q, resp_sent_d;

    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       clr_rx_rdy;
    logic       trmt;
    logic       tx_done;
    logic [7:0] tx_data;
    logic       to_expire;

    UART #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .TX         (TX),
        .tx_data    (tx_data),
        .trmt       (trmt),
        .tx_done    (tx_done),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .clr_rx_rdy (clr_rx_rdy)
    );

    assign to_expire = (to_cnt_q == TO_LAST);

    // Frame assembly, inter-byte timeout and cmd_rdy/overrun flag handling.
    // A completing frame takes priority over a same-cycle acknowledge.
    always_comb begin
        rx_state_d = rx_state_q;
        cmd_sh_d   = cmd_sh_q;
        hi_sh_d    = hi_sh_q;
        cmd_d      = cmd_q;
        data_d     = data_q;
        cmd_rdy_d  = cmd_rdy_q;
        overrun_d  = overrun_q;
        frm_err_d  = 1'b0;
        to_cnt_d   = to_cnt_q;
        clr_rx_rdy = 1'b0;

        if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
            overrun_d = 1'b0;
        end

        unique case (rx_state_q)
            WAIT_CMD: begin
                to_cnt_d = '0;
                if (rx_rdy) begin
                    clr_rx_rdy = 1'b1;
                    cmd_sh_d   = rx_data;
                    rx_state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (rx_rdy) begin
                    clr_rx_rdy = 1'b1;
                    hi_sh_d    = rx_data;
                    to_cnt_d   = '0;
                    rx_state_d = WAIT_LO;
                end else if (to_expire) begin
                    cmd_sh_d   = 8'h00;
                    hi_sh_d    = 8'h00;
                    to_cnt_d   = '0;
                    frm_err_d  = 1'b1;
                    rx_state_d = WAIT_CMD;
                end else begin
                    to_cnt_d = to_cnt_q + CNT_ONE;
                end
            end
            WAIT_LO: begin
                if (rx_rdy) begin
                    clr_rx_rdy = 1'b1;
                    cmd_d      = cmd_sh_q;
                    data_d     = {hi_sh_q, rx_data};
                    if (cmd_rdy_q && !clr_cmd_rdy) begin
                        overrun_d = 1'b1;
                    end
                    cmd_rdy_d  = 1'b1;
                    to_cnt_d   = '0;
                    rx_state_d = WAIT_CMD;
                end else if (to_expire) begin
                    cmd_sh_d   = 8'h00;
                    hi_sh_d    = 8'h00;
                    to_cnt_d   = '0;
                    frm_err_d  = 1'b1;
                    rx_state_d = WAIT_CMD;
                end else begin
                    to_cnt_d = to_cnt_q + CNT_ONE;
                end
            end
            default: begin
                rx_state_d = WAIT_CMD;
            end
        endcase
    end

    // Receive-side state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= WAIT_CMD;
            cmd_sh_q   <= 8'h00;
            hi_sh_q    <= 8'h00;
            cmd_q      <= 8'h00;
            data_q     <= 16'h0000;
            cmd_rdy_q  <= 1'b0;
            overrun_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            to_cnt_q   <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            cmd_sh_q   <= cmd_sh_d;
            hi_sh_q    <= hi_sh_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            cmd_rdy_q  <= cmd_rdy_d;
            overrun_q  <= overrun_d;
            frm_err_q  <= frm_err_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    // Response launch: one request per transmission, extra requests while
    // busy are dropped. The UART takes the byte directly from resp in the
    // launch cycle.
    always_comb begin
        tx_state_d  = tx_state_q;
        resp_d      = resp_q;
        resp_sent_d = resp_sent_q;
        trmt        = 1'b0;
        tx_data     = resp_q;

        case (tx_state_q)
            TX_IDLE: begin
                if (send_resp) begin
                    resp_d      = resp;
                    tx_data     = resp;
                    trmt        = 1'b1;
                    resp_sent_d = 1'b0;
                    tx_state_d  = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (tx_done) begin
                    resp_sent_d = 1'b1;
                    tx_state_d  = TX_IDLE;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    // Transmit-side state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q  <= TX_IDLE;
            resp_q      <= 8'h00;
            resp_sent_q <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            resp_q      <= resp_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    assign cmd       = cmd_q;
    assign data      = data_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign overrun   = overrun_q;
    assign frm_err   = frm_err_q;
    assign resp_sent = resp_sent_q;
    assign tx_busy   = (tx_state_q == TX_BUSY);

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// Bench for uart_cmd_rcv: drives serial frames, decodes the TX line, and
// compares outputs against a frame-level model of the command endpoint.

module tb_uart_cmd_rcv;
    localparam int BAUD = 16;
    localparam int TO   = 30000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        TX;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        resp_sent;
    logic        tx_busy;
    logic        frm_err;
    logic        overrun;

    int n_chk = 0;
    int n_err = 0;

    // Frame-level model of what the consumer should see.
    logic [7:0]  m_cmd  = 8'h00;
    logic [15:0] m_data = 16'h0000;
    logic        m_rdy  = 1'b0;
    logic        m_ovr  = 1'b0;

    always #5 clk = ~clk;

    uart_cmd_rcv #(
        .TIMEOUT_CYCLES (TO),
        .BAUD_DIV       (BAUD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .data        (data),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent),
        .tx_busy     (tx_busy),
        .frm_err     (frm_err),
        .overrun     (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".cmd"},  32'(cmd),     32'(m_cmd));
        chk({tag, ".data"}, 32'(data),    32'(m_data));
        chk({tag, ".rdy"},  32'(cmd_rdy), 32'(m_rdy));
        chk({tag, ".ovr"},  32'(overrun), 32'(m_ovr));
    endtask

    task automatic m_complete(input logic [7:0] c, input logic [15:0] d, input bit clr_same);
        m_ovr  = clr_same ? 1'b0 : (m_ovr | m_rdy);
        m_rdy  = 1'b1;
        m_cmd  = c;
        m_data = d;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            RX = fr[i];
            repeat (BAUD - 1) @(negedge clk);
        end
    endtask

    task automatic wait_rx_rdy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12 * BAUD; i++) begin
            @(negedge clk);
            if (dut.rx_rdy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l,
                              input int gap, input bit clr_same, input string tag);
        bit ok;
        send_byte(c);
        repeat (gap) @(negedge clk);
        send_byte(h);
        repeat (gap) @(negedge clk);
        fork
            send_byte(l);
            begin
                wait_rx_rdy(ok);
                chk({tag, ".rxrdy"}, 32'(ok), 32'd1);
                if (ok) begin
                    chk({tag, ".pre"}, 32'(cmd_rdy), 32'(m_rdy));
                    if (clr_same) clr_cmd_rdy = 1'b1;
                    @(posedge clk);
                    #1;
                    clr_cmd_rdy = 1'b0;
                    m_complete(c, {h, l}, clr_same);
                    chk_all(tag);
                end
            end
        join
    endtask

    task automatic pulse_clr(input string tag);
        @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        clr_cmd_rdy = 1'b0;
        m_rdy = 1'b0;
        m_ovr = 1'b0;
        chk_all(tag);
    endtask

    task automatic mon_tx(output logic [7:0] b, output bit ok);
        ok = 1'b0;
        b  = 8'h00;
        for (int i = 0; i < 4 * BAUD; i++) begin
            @(negedge clk);
            if (!TX) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            repeat (BAUD / 2) @(negedge clk);
            if (TX) ok = 1'b0;
            for (int j = 0; j < 8; j++) begin
                repeat (BAUD) @(negedge clk);
                b[j] = TX;
            end
            repeat (BAUD) @(negedge clk);
            if (!TX) ok = 1'b0;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".cmd"},   32'(cmd),       32'h00);
        chk({tag, ".data"},  32'(data),      32'h0000);
        chk({tag, ".rdy"},   32'(cmd_rdy),   32'd0);
        chk({tag, ".ovr"},   32'(overrun),   32'd0);
        chk({tag, ".ferr"},  32'(frm_err),   32'd0);
        chk({tag, ".sent"},  32'(resp_sent), 32'd0);
        chk({tag, ".busy"},  32'(tx_busy),   32'd0);
        chk({tag, ".tx"},    32'(TX),        32'd1);
    endtask

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ok;
        bit         mon_ok;
        bit         done_seen;
        bit         quiet;
        int         pulses;
        int         at;
        logic [7:0] rb;
        logic [7:0] c, h, l;
        int         gap;
        bit         cs;

        repeat (3) @(negedge clk);
        chk_reset_vals("rst_in");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst_out");

        // Basic frame and acknowledge
        send_frame(8'h02, 8'h12, 8'h34, 0, 1'b0, "f1");
        pulse_clr("f1_clr");

        // Two frames without acknowledge: overrun
        send_frame(8'h05, 8'hAB, 8'hCD, 0, 1'b0, "ov_a");
        send_frame(8'h06, 8'h00, 8'h01, 0, 1'b0, "ov_b");
        pulse_clr("ov_clr");

        // Partial frame followed by silence
        send_byte(8'h03);
        pulses = 0;
        at     = -1;
        fork
            send_byte(8'h55);
            begin
                wait_rx_rdy(ok);
                chk("to.acc", 32'(ok), 32'd1);
                @(posedge clk);
                for (int k = 1; k <= TO + 100; k++) begin
                    @(posedge clk);
                    #1;
                    if (frm_err) begin
                        pulses++;
                        if (at < 0) at = k;
                    end
                end
            end
        join
        chk("to.pulses", 32'(pulses), 32'd1);
        chk("to.cycle", 32'(at), 32'(TO));
        chk_all("to.hold");
        send_frame(8'h04, 8'h11, 8'h22, 0, 1'b0, "after_to");

        // Completion and acknowledge in the same cycle
        send_frame(8'h07, 8'hFF, 8'hFF, 0, 1'b1, "same");
        pulse_clr("same_clr");

        // Response transmission
        resp = 8'hA5;
        @(negedge clk);
        send_resp = 1'b1;
        @(posedge clk);
        #1;
        send_resp = 1'b0;
        chk("tx.busy0", 32'(tx_busy), 32'd1);
        chk("tx.sent0", 32'(resp_sent), 32'd0);
        done_seen = 1'b0;
        fork
            mon_tx(rb, mon_ok);
            begin
                repeat (3 * BAUD) @(negedge clk);
                resp = 8'h3C;
                send_resp = 1'b1;
                @(negedge clk);
                send_resp = 1'b0;
                chk("tx.busy_mid", 32'(tx_busy), 32'd1);
            end
            begin
                for (int i = 0; i < 14 * BAUD; i++) begin
                    @(negedge clk);
                    if (dut.tx_done) begin
                        done_seen = 1'b1;
                        break;
                    end
                end
                chk("tx.done_seen", 32'(done_seen), 32'd1);
                chk("tx.busy_at_done", 32'(tx_busy), 32'd1);
                chk("tx.sent_at_done", 32'(resp_sent), 32'd0);
                @(posedge clk);
                #1;
                chk("tx.sent", 32'(resp_sent), 32'd1);
                chk("tx.busy_end", 32'(tx_busy), 32'd0);
            end
        join
        chk("tx.frame", 32'(mon_ok), 32'd1);
        chk("tx.byte", 32'(rb), 32'hA5);
        quiet = 1'b1;
        for (int i = 0; i < 12 * BAUD; i++) begin
            @(negedge clk);
            if (!TX) quiet = 1'b0;
        end
        chk("tx.ignored", 32'(quiet), 32'd1);

        // Randomised frames with random gaps and acknowledges
        for (int f = 0; f < 14; f++) begin
            c   = 8'($urandom);
            h   = 8'($urandom);
            l   = 8'($urandom);
            gap = $urandom_range(0, 40);
            cs  = ($urandom_range(0, 3) == 0);
            send_frame(c, h, l, gap, cs, "rnd");
            if ($urandom_range(0, 1) == 1) pulse_clr("rnd_clr");
        end

        // Reset during a partial frame and an active transmission
        send_frame(8'h81, 8'hC3, 8'h3C, 0, 1'b0, "pre_rst");
        send_byte(8'h09);
        send_byte(8'h77);
        resp = 8'h5A;
        @(negedge clk);
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        repeat (BAUD + 4) @(negedge clk);
        chk("rst.pre_busy", 32'(tx_busy), 32'd1);
        chk("rst.pre_tx", 32'(TX), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        m_cmd  = 8'h00;
        m_data = 16'h0000;
        m_rdy  = 1'b0;
        m_ovr  = 1'b0;
        chk_reset_vals("rst_mid");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst_rel");
        send_frame(8'h3E, 8'h9D, 8'h41, 0, 1'b0, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rcv.md
# uart_cmd_rcv

Flight-controller-side UART command endpoint. It receives 3-byte command frames (cmd, data high, data low) from the remote/test-bench link and presents them as a parallel 8-bit command plus 16-bit data with a ready flag. It also transmits 8-bit responses back on the same link. It sits between the serial pins and the command-processing block, and instantiates the team's existing 8-bit `UART` transceiver (tx_data/trmt/tx_done, rx_data/rx_rdy/clr_rx_rdy).

## Interface
- TIMEOUT_CYCLES, default 100000: maximum idle cycles between bytes of one frame before the partial frame is discarded. Counter width is $clog2(TIMEOUT_CYCLES).
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- RX  in  1  serial input
- TX  out  1  serial output
- cmd  out  8  opcode of the last complete frame
- data  out  16  payload of the last complete frame, {byte2, byte3}
- cmd_rdy  out  1  complete frame available
- clr_cmd_rdy  in  1  consumer acknowledge; clears cmd_rdy and overrun
- resp  in  8  response byte to send
- send_resp  in  1  one-cycle request to transmit resp
- resp_sent  out  1  response transmission complete
- tx_busy  out  1  response transmission in progress
- frm_err  out  1  one-cycle pulse when a partial frame times out
- overrun  out  1  sticky; a frame completed while cmd_rdy was already 1

## Operation
- Receive FSM states: WAIT_CMD, WAIT_HI, WAIT_LO. Reset state is WAIT_CMD.
- Any state, UART rx_rdy=1: the byte is accepted and clr_rx_rdy is asserted combinationally in the same cycle.
  - WAIT_CMD: byte goes to the cmd shadow register; next state WAIT_HI.
  - WAIT_HI: byte goes to the data-high shadow register; next state WAIT_LO.
  - WAIT_LO: cmd and data outputs load {shadow cmd, shadow hi, rx_data} in one edge; cmd_rdy is set; next state WAIT_CMD.
- cmd and data change only at frame completion. They hold their values while the next frame is being received.
- Frame completes while cmd_rdy=1: outputs are overwritten, cmd_rdy stays 1, overrun is set.
- clr_cmd_rdy clears both cmd_rdy and overrun.
- Frame completion and clr_cmd_rdy in the same cycle: completion wins. cmd_rdy=1, overrun is not set.
- Timeout counter:
  - Cleared in WAIT_CMD and on every accepted byte.
  - Increments each cycle in WAIT_HI or WAIT_LO.
  - Reaching TIMEOUT_CYCLES-1 with no rx_rdy: next state WAIT_CMD, shadow bytes discarded, frm_err pulses for 1 cycle, outputs and cmd_rdy unchanged.
  - rx_rdy in the expiry cycle: the byte is accepted and no timeout occurs.
- Transmit FSM states: TX_IDLE, TX_BUSY.
  - TX_IDLE with send_resp: resp is latched, trmt pulses for 1 cycle, resp_sent clears, state goes to TX_BUSY.
  - TX_BUSY: tx_done sets resp_sent and returns the FSM to TX_IDLE.
  - send_resp in TX_BUSY is ignored (no queueing).
- tx_busy = (state == TX_BUSY).
- Receive and transmit paths operate concurrently and independently.
- Reset mid-frame or mid-transmit: both FSMs go to their idle states and all outputs take their reset values. Partial data is lost.

## Timing
- Reset values: cmd=8'h00, data=16'h0000, cmd_rdy=0, overrun=0, frm_err=0, resp_sent=0, tx_busy=0, TX=1 (UART idle).
- Command latency: rx_rdy of the third byte at edge N gives cmd, data and cmd_rdy valid after edge N+1. The delay is 1 clk; no extra pipeline.
- clr_cmd_rdy sampled at edge N gives cmd_rdy=0 after edge N.
- send_resp at edge N gives trmt high during cycle N and tx_busy=1 after edge N.
- resp_sent goes to 1 one cycle after tx_done.
- Timeout: frm_err is high exactly TIMEOUT_CYCLES cycles after the last accepted byte, for 1 cycle.
- Back-to-back frames need no idle gap. A cmd byte arriving the cycle after completion is accepted.

## Test plan
- Send frame 0x02, 0x12, 0x34. Required: cmd=0x02, data=0x1234, cmd_rdy=1 one clk after the third rx_rdy. Pulse clr_cmd_rdy: cmd_rdy=0, outputs held.
- Send two frames (0x05,0xAB,0xCD then 0x06,0x00,0x01) with no clr_cmd_rdy. Required: cmd=0x06, data=0x0001, cmd_rdy=1, overrun=1. Pulse clr_cmd_rdy: both flags 0.
- Send 0x03, 0x55, then silence (TIMEOUT_CYCLES=30000). Required: frm_err pulses once; FSM is in WAIT_CMD. Then send 0x04,0x11,0x22: cmd=0x04, data=0x1122.
- Assert clr_cmd_rdy in the same cycle as the completing byte of frame 0x07,0xFF,0xFF. Required: cmd_rdy=1, overrun=0.
- send_resp with resp=0xA5; loop TX back to a monitor UART. Required: 0xA5 received; tx_busy=1 until tx_done; resp_sent=1 one clk after tx_done. A second send_resp during busy is ignored.
- Assert rst_n low mid-frame and mid-transmit. Required: all outputs at reset values, TX=1. A fresh frame afterwards decodes correctly.
